// File: rtl/iir_a3_s2p_packer_if.sv
// ---------------------------------------------------------------------------
// iir_a3_s2p_packer_if
// Bundles the sample-side and word-side signals of the serial-to-parallel
// packer that feeds the 3-lane parallel IIR filter.
//
// Signals
//   s_data        sample from the upstream source (DW bits, signed)
//   s_valid       s_data is valid this cycle (no backpressure)
//   sync          this cycle's sample is lane 0 of a new block
//   flush         end of block, resolve any partial word
//   err_clr       clear the sticky sync_err flag
//   data_out      packed word, lane 0 (oldest sample) in the top DW bits
//   data_out_en   one-cycle strobe, data_out is valid
//   data_out_pad  with data_out_en: the word was zero-padded
//   phase         lane index the next sample will fill
//   sync_err      sticky: a sync or flush hit a partial word
//   word_cnt      number of data_out_en strobes, wraps
//
// Modports
//   master  sample source / word consumer side
//   slave   the packer itself
// ---------------------------------------------------------------------------
interface iir_a3_s2p_packer_if #(
  parameter int DW    = 16,
  parameter int LANES = 3,
  parameter int CNT_W = 16
);

  logic [DW-1:0]       s_data;
  logic                s_valid;
  logic                sync;
  logic                flush;
  logic                err_clr;
  logic [LANES*DW-1:0] data_out;
  logic                data_out_en;
  logic                data_out_pad;
  logic [1:0]          phase;
  logic                sync_err;
  logic [CNT_W-1:0]    word_cnt;

  modport master (
    output s_data, s_valid, sync, flush, err_clr,
    input  data_out, data_out_en, data_out_pad, phase, sync_err, word_cnt
  );

  modport slave (
    input  s_data, s_valid, sync, flush, err_clr,
    output data_out, data_out_en, data_out_pad, phase, sync_err, word_cnt
  );

endinterface

// File: rtl/iir_a3_s2p_packer.sv
// ---------------------------------------------------------------------------
// iir_a3_s2p_packer
// Serial-to-parallel front end for the 3-lane parallel IIR filter. Consecutive
// DW-bit samples are collected into one LANES*DW word (oldest sample in the
// top lane) and issued one cycle after the last sample with a one-cycle
// enable. sync realigns the lane counter to a block start, flush resolves a
// partial word at the end of a block, and both raise the sticky sync_err when
// they land on a partial word.
//
// Build option
//   IIR_A3_S2P_ZERO_PAD_EN  defined: a partial word on sync/flush is emitted
//                           zero-padded with data_out_pad=1.
//                           undefined: the partial word is discarded and
//                           data_out_pad is tied low.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   iir_a3_s2p_packer_if.slave (sample inputs, word outputs, status)
//
// phase is two bits wide, so LANES must lie between 1 and 4.
// ---------------------------------------------------------------------------
module iir_a3_s2p_packer #(
  parameter int DW    = 16,
  parameter int LANES = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  iir_a3_s2p_packer_if.slave   bus
);

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  logic [DW-1:0]       lane_q [LANES];
  logic [DW-1:0]       lane_d [LANES];
  logic [1:0]          phase_q, phase_d;
  logic [LANES*DW-1:0] dataOut_q, dataOut_d;
  logic                dataOutEn_q, dataOutEn_d;
  logic                syncErr_q, syncErr_d;
  logic [CNT_W-1:0]    wordCnt_q, wordCnt_d;

  logic [1:0]          effPhase;
  logic [1:0]          afterPhase;
  logic                complete;
  logic                syncPartial;
  logic                flushPartial;
  logic                resolve;
  logic [LANES*DW-1:0] fullWord;

`ifdef IIR_A3_S2P_ZERO_PAD_EN
  logic                dataOutPad_q, dataOutPad_d;
  logic [1:0]          fillCnt;
  logic [LANES*DW-1:0] padWord;
`endif

  // Capture and word assembly. sync forces the capture lane to 0, so a sync
  // on a partial word abandons the old lanes. On a sync the padded word is
  // built from the lanes as they stood before this cycle (lane 0 may be
  // overwritten by the new sample); on a flush it includes this cycle's
  // sample. A sample that completes a word takes priority over a flush.
  always_comb begin
    effPhase = bus.sync ? 2'd0 : phase_q;
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = lane_q[i];
    end
    if (bus.s_valid) begin
      lane_d[effPhase] = bus.s_data;
    end
    afterPhase   = bus.s_valid ? (effPhase + 2'd1) : effPhase;
    complete     = bus.s_valid && (effPhase == LAST_LANE);
    syncPartial  = bus.sync && (phase_q != 2'd0);
    flushPartial = bus.flush && !bus.sync && !complete && (afterPhase != 2'd0);
    resolve      = syncPartial || flushPartial;
    fullWord     = '0;
    for (int i = 0; i < LANES; i++) begin
      fullWord[(LANES-1-i)*DW +: DW] = lane_d[i];
    end
`ifdef IIR_A3_S2P_ZERO_PAD_EN
    fillCnt = syncPartial ? phase_q : afterPhase;
    padWord = '0;
    for (int i = 0; i < LANES; i++) begin
      if (2'(i) < fillCnt) begin
        padWord[(LANES-1-i)*DW +: DW] = syncPartial ? lane_q[i] : lane_d[i];
      end
    end
`endif
  end

  // Output word, strobe, phase, counter and sticky error. Only one word is
  // ever emitted per cycle; the counter advances with every strobe,
  // including padded ones. Setting sync_err wins over err_clr.
  always_comb begin
    phase_d     = (complete || flushPartial) ? 2'd0 : afterPhase;
    dataOut_d   = dataOut_q;
    dataOutEn_d = 1'b0;
`ifdef IIR_A3_S2P_ZERO_PAD_EN
    dataOutPad_d = 1'b0;
`endif
    if (complete) begin
      dataOut_d   = fullWord;
      dataOutEn_d = 1'b1;
    end
`ifdef IIR_A3_S2P_ZERO_PAD_EN
    else if (resolve) begin
      dataOut_d    = padWord;
      dataOutEn_d  = 1'b1;
      dataOutPad_d = 1'b1;
    end
`endif
    wordCnt_d = dataOutEn_d ? (wordCnt_q + 1'b1) : wordCnt_q;
    if (resolve) begin
      syncErr_d = 1'b1;
    end else if (bus.err_clr) begin
      syncErr_d = 1'b0;
    end else begin
      syncErr_d = syncErr_q;
    end
  end

  // State registers; reset discards any partial word in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
      phase_q     <= 2'd0;
      dataOut_q   <= '0;
      dataOutEn_q <= 1'b0;
      syncErr_q   <= 1'b0;
      wordCnt_q   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= lane_d[i];
      end
      phase_q     <= phase_d;
      dataOut_q   <= dataOut_d;
      dataOutEn_q <= dataOutEn_d;
      syncErr_q   <= syncErr_d;
      wordCnt_q   <= wordCnt_d;
    end
  end

`ifdef IIR_A3_S2P_ZERO_PAD_EN
  // Pad flag register, only present when padded words can be emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOutPad_q <= 1'b0;
    end else begin
      dataOutPad_q <= dataOutPad_d;
    end
  end

  assign bus.data_out_pad = dataOutPad_q;
`else
  assign bus.data_out_pad = 1'b0;
`endif

  assign bus.data_out    = dataOut_q;
  assign bus.data_out_en = dataOutEn_q;
  assign bus.phase       = phase_q;
  assign bus.sync_err    = syncErr_q;
  assign bus.word_cnt    = wordCnt_q;

endmodule

// File: tb/tb_iir_a3_s2p_packer.sv
// ---------------------------------------------------------------------------
// tb_iir_a3_s2p_packer
// Drives the packer with directed and random sample streams and compares it
// against a queue-based model of the packing rules. A second instance with a
// 4-bit word counter runs in parallel so that counter wrap-around is reached
// in a short run.
// ---------------------------------------------------------------------------
module tb_iir_a3_s2p_packer;

  localparam int DW      = 16;
  localparam int LANES   = 3;
  localparam int CNT_W   = 16;
  localparam int SMALL_W = 4;
`ifdef IIR_A3_S2P_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  // 10 ns clock
  always #5 clk = ~clk;

  iir_a3_s2p_packer_if #(.DW(DW), .LANES(LANES), .CNT_W(CNT_W))   bus ();
  iir_a3_s2p_packer_if #(.DW(DW), .LANES(LANES), .CNT_W(SMALL_W)) busS ();

  // The small-counter instance sees exactly the same stimulus.
  assign busS.s_data  = bus.s_data;
  assign busS.s_valid = bus.s_valid;
  assign busS.sync    = bus.sync;
  assign busS.flush   = bus.flush;
  assign busS.err_clr = bus.err_clr;

  iir_a3_s2p_packer #(.DW(DW), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  iir_a3_s2p_packer #(.DW(DW), .LANES(LANES), .CNT_W(SMALL_W)) dutS (
    .clk (clk),
    .rst (rst),
    .bus (busS)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: samples of the word in progress, plus expected outputs.
  logic [DW-1:0]       pend [$];
  logic [LANES*DW-1:0] expData;
  logic                expEn;
  logic                expPad;
  logic                expErr;
  logic [1:0]          expPhase;
  logic [CNT_W-1:0]    expCnt;

  // Pack the pending samples, oldest in the top lane, unfilled lanes zero.
  function automatic logic [LANES*DW-1:0] packPending();
    logic [LANES*DW-1:0] r;
    r = '0;
    for (int i = 0; i < pend.size(); i++) begin
      r[(LANES-1-i)*DW +: DW] = pend[i];
    end
    return r;
  endfunction

  task automatic modelReset();
    pend.delete();
    expData  = '0;
    expEn    = 1'b0;
    expPad   = 1'b0;
    expErr   = 1'b0;
    expPhase = 2'd0;
    expCnt   = '0;
  endtask

  // Apply one cycle of inputs, advance the model, and return #1 after the
  // clock edge so that outputs can be sampled.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit sy,
                      input bit fl, input bit ec);
    bit                  emit;
    bit                  pad;
    bit                  res;
    bit                  outEn;
    logic [LANES*DW-1:0] w;
    emit = 1'b0;
    pad  = 1'b0;
    res  = 1'b0;
    w    = '0;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.sync    = sy;
    bus.flush   = fl;
    bus.err_clr = ec;
    if (sy && pend.size() != 0) begin
      res = 1'b1;
      pad = 1'b1;
      w   = packPending();
      pend.delete();
    end
    if (v) pend.push_back(d);
    if (pend.size() == LANES) begin
      emit = 1'b1;
      pad  = 1'b0;
      w    = packPending();
      pend.delete();
    end else if (fl && !sy && pend.size() != 0) begin
      res = 1'b1;
      pad = 1'b1;
      w   = packPending();
      pend.delete();
    end
    outEn = emit || (res && PAD_EN);
    @(posedge clk);
    #1;
    cycle++;
    expEn  = outEn;
    expPad = outEn && pad;
    if (outEn) begin
      expData = w;
      expCnt  = expCnt + 1'b1;
    end
    if (res) expErr = 1'b1;
    else if (ec) expErr = 1'b0;
    expPhase = 2'(pend.size());
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.sync    = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.sync    = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.phase,
         bus.sync_err, bus.word_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got data=%h en=%b pad=%b phase=%0d err=%b cnt=%0d required all zero",
               bus.data_out, bus.data_out_en, bus.data_out_pad, bus.phase,
               bus.sync_err, bus.word_cnt);
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_basic_word();
    doReset();
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.data_out_en !== 1'b0 || bus.phase !== 2'd2) begin
      errors++;
      $display("[TB] FAIL basic_partial: got en=%b phase=%0d required en=0 phase=2",
               bus.data_out_en, bus.phase);
    end
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt, bus.phase}
        !== {48'h0001_0002_0003, 1'b1, 1'b0, 16'd1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL basic_word: got data=%h en=%b pad=%b cnt=%0d phase=%0d required data=000100020003 en=1 pad=0 cnt=1 phase=0",
               bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt, bus.phase);
    end
    idle();
    checks++;
    if (bus.data_out_en !== 1'b0 || bus.data_out !== 48'h0001_0002_0003) begin
      errors++;
      $display("[TB] FAIL basic_hold: got en=%b data=%h required en=0 data=000100020003",
               bus.data_out_en, bus.data_out);
    end
  endtask

  task automatic test_continuous();
    logic [LANES*DW-1:0] table_w [3];
    int k;
    int lastCyc;
    table_w[0] = 48'h0001_0002_0003;
    table_w[1] = 48'h0004_0005_0006;
    table_w[2] = 48'h0007_0008_0009;
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      k = 0;
      lastCyc = 0;
      for (int s = 1; s <= 9; s++) begin
        if (pass == 1) begin
          for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
        end
        step(1'b1, 16'(s), 1'b0, 1'b0, 1'b0);
        if (bus.data_out_en === 1'b1) begin
          checks++;
          if (k >= 3 || bus.data_out !== table_w[k % 3]) begin
            errors++;
            $display("[TB] FAIL stream_word pass %0d idx %0d: got %h required %h",
                     pass, k, bus.data_out, table_w[k % 3]);
          end
          if (pass == 0 && k > 0) begin
            checks++;
            if (cycle - lastCyc != 3) begin
              errors++;
              $display("[TB] FAIL stream_spacing: got %0d clks required 3", cycle - lastCyc);
            end
          end
          lastCyc = cycle;
          k++;
        end
      end
      idle();
      checks++;
      if (k != 3 || bus.word_cnt !== 16'd3) begin
        errors++;
        $display("[TB] FAIL stream_count pass %0d: got strobes=%0d cnt=%0d required 3 and 3",
                 pass, k, bus.word_cnt);
      end
    end
  endtask

  task automatic test_sync_realign();
    doReset();
    step(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.sync_err, bus.data_out_en, bus.data_out_pad, bus.phase, bus.data_out}
        !== {1'b1, PAD_EN, PAD_EN, 2'd1, (PAD_EN ? 48'h8000_7FFF_0000 : 48'h0)}) begin
      errors++;
      $display("[TB] FAIL sync_pad: got err=%b en=%b pad=%b phase=%0d data=%h required err=1 en=%b pad=%b phase=1",
               bus.sync_err, bus.data_out_en, bus.data_out_pad, bus.phase, bus.data_out,
               PAD_EN, PAD_EN);
    end
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt}
        !== {48'h1234_5555_6666, 1'b1, 1'b0, (PAD_EN ? 16'd2 : 16'd1)}) begin
      errors++;
      $display("[TB] FAIL sync_next_word: got data=%h en=%b pad=%b cnt=%0d required data=123455556666 en=1 pad=0",
               bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt);
    end
  endtask

  task automatic test_flush();
    doReset();
    step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt, bus.sync_err, bus.phase}
        !== {(PAD_EN ? 48'hABCD_0000_0000 : 48'h0), PAD_EN, PAD_EN,
             (PAD_EN ? 16'd1 : 16'd0), 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL flush_partial: got data=%h en=%b pad=%b cnt=%0d err=%b phase=%0d (pad build=%b)",
               bus.data_out, bus.data_out_en, bus.data_out_pad, bus.word_cnt,
               bus.sync_err, bus.phase, PAD_EN);
    end
    // flush on the completing sample is an ordinary word
    step(1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0C0C, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.sync_err}
        !== {48'h0A0A_0B0B_0C0C, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL flush_complete: got data=%h en=%b pad=%b err=%b required data=0a0a0b0b0c0c en=1 pad=0 err=0",
               bus.data_out, bus.data_out_en, bus.data_out_pad, bus.sync_err);
    end
  endtask

  task automatic test_err_clr();
    doReset();
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.sync_err !== 1'b1 || bus.phase !== 2'd0) begin
      errors++;
      $display("[TB] FAIL errclr_set_wins: got err=%b phase=%0d required err=1 phase=0",
               bus.sync_err, bus.phase);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.sync_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL errclr_clear: got err=%b required 0", bus.sync_err);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] a, b, c;
    doReset();
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.phase,
         bus.sync_err, bus.word_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got data=%h en=%b phase=%0d cnt=%0d required all zero",
               bus.data_out, bus.data_out_en, bus.phase, bus.word_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    step(1'b1, a, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.data_out, bus.data_out_en, bus.word_cnt} !== {a, b, c, 1'b1, 16'd1}) begin
      errors++;
      $display("[TB] FAIL reset_no_stale: got data=%h en=%b cnt=%0d required data=%h%h%h en=1 cnt=1",
               bus.data_out, bus.data_out_en, bus.word_cnt, a, b, c);
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int w = 0; w < 16; w++) begin
      for (int s = 0; s < LANES; s++) begin
        step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      end
    end
    checks++;
    if (busS.word_cnt !== 4'd0 || busS.data_out_en !== 1'b1 || bus.word_cnt !== 16'd16) begin
      errors++;
      $display("[TB] FAIL cnt_wrap: got small=%0d en=%b wide=%0d required small=0 en=1 wide=16",
               busS.word_cnt, busS.data_out_en, bus.word_cnt);
    end
  endtask

  task automatic test_random();
    bit            v, sy, fl, ec;
    logic [DW-1:0] d;
    doReset();
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 9) < 7);
      sy = ($urandom_range(0, 11) == 0);
      fl = ($urandom_range(0, 9) == 0);
      ec = ($urandom_range(0, 7) == 0);
      d  = 16'($urandom);
      step(v, d, sy, fl, ec);
      checks++;
      if ({bus.data_out, bus.data_out_en, bus.data_out_pad, bus.phase, bus.sync_err, bus.word_cnt}
          !== {expData, expEn, expPad, expPhase, expErr, expCnt}) begin
        errors++;
        $display("[TB] FAIL random_cycle %0d: got data=%h en=%b pad=%b phase=%0d err=%b cnt=%0d required data=%h en=%b pad=%b phase=%0d err=%b cnt=%0d",
                 n, bus.data_out, bus.data_out_en, bus.data_out_pad, bus.phase,
                 bus.sync_err, bus.word_cnt, expData, expEn, expPad, expPhase,
                 expErr, expCnt);
      end
      checks++;
      if (busS.word_cnt !== expCnt[SMALL_W-1:0] || busS.data_out !== expData) begin
        errors++;
        $display("[TB] FAIL random_small %0d: got cnt=%0d data=%h required cnt=%0d data=%h",
                 n, busS.word_cnt, busS.data_out, expCnt[SMALL_W-1:0], expData);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_continuous();
    test_sync_realign();
    test_flush();
    test_err_clr();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
